// File: rtl/alu_pkg.sv
// Shared types and the single-cycle evaluation helper for the multi-cycle ALU.
// alu_comb works on ALU_MAXW-bit containers; callers zero-extend operands and truncate the result.
package alu_pkg;

    localparam int unsigned ALU_MAXW  = 64;
    localparam int unsigned ALU_IDXW  = 6;
    localparam int unsigned ALU_IDXW1 = ALU_IDXW + 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SHR  = 4'd8,
        OP_SRA  = 4'd9,
        OP_SLT  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_t;

    typedef struct packed {
        logic ovf;
        logic neg;
        logic carry;
        logic zero;
    } alu_flags_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_RESULT = 2'd2
    } alu_state_t;

    // Flags sit in the low bits so a caller can size-cast to {y[W-1:0], flags}.
    typedef struct packed {
        logic [ALU_MAXW-1:0] y;
        alu_flags_t          flags;
    } alu_res_t;

    function automatic alu_res_t alu_comb(
        input logic [ALU_MAXW-1:0] a,
        input logic [ALU_MAXW-1:0] b,
        input alu_op_t             op,
        input int unsigned         sh,
        input int unsigned         w
    );
        alu_res_t              r;
        logic [ALU_MAXW-1:0]   mask;
        logic [ALU_MAXW-1:0]   sext_a;
        logic [ALU_MAXW-1:0]   sext_b;
        logic [ALU_MAXW:0]     wide;
        logic [ALU_IDXW-1:0]   msb;
        logic                  sa;
        logic                  sb;

        r      = '0;
        wide   = '0;
        msb    = ALU_IDXW'(w - 1);
        mask   = (w >= ALU_MAXW) ? '1 : ((ALU_MAXW'(1) << w) - ALU_MAXW'(1));
        sa     = a[msb];
        sb     = b[msb];
        sext_a = sa ? (a | ~mask) : a;
        sext_b = sb ? (b | ~mask) : b;

        case (op)
            OP_ADD: begin
                wide          = {1'b0, a} + {1'b0, b};
                r.y           = wide[ALU_MAXW-1:0] & mask;
                r.flags.carry = wide[ALU_IDXW1'(w)];
                r.flags.ovf   = (sa == sb) && (r.y[msb] != sa);
            end
            OP_SUB: begin
                wide          = {1'b0, a} - {1'b0, b};
                r.y           = wide[ALU_MAXW-1:0] & mask;
                r.flags.carry = (a < b);
                r.flags.ovf   = (sa != sb) && (r.y[msb] != sa);
            end
            OP_AND:  r.y = a & b;
            OP_OR:   r.y = a | b;
            OP_XOR:  r.y = a ^ b;
            OP_NOT:  r.y = ~a & mask;
            OP_SHL: begin
                r.y = (a << sh) & mask;
                if (sh == 0)      r.flags.carry = 1'b0;
                else if (sh >= w) r.flags.carry = a[0];
                else              r.flags.carry = a[ALU_IDXW'(w - sh)];
            end
            OP_SLTU: r.y = ALU_MAXW'(a < b);
            OP_SHR, OP_SRA: begin
                if (op == OP_SRA) r.y = ($signed(sext_a) >>> sh) & mask;
                else              r.y = a >> sh;
                if (sh == 0)      r.flags.carry = 1'b0;
                else if (sh >= w) r.flags.carry = a[msb];
                else              r.flags.carry = a[ALU_IDXW'(sh - 1)];
            end
            OP_SLT:  r.y = ALU_MAXW'($signed(sext_a) < $signed(sext_b));
            default: r.y = '0;
        endcase

        r.flags.zero = (r.y == '0);
        if (op < OP_MUL) r.flags.neg = r.y[msb];
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per step, WIDTH steps.
// o_done_c/o_prod_c are valid in the cycle of the final step.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done_c,
    output logic [2*WIDTH-1:0] o_prod_c
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    w_acc_nx;

    assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_prod_c = w_acc_nx;
    assign o_done_c = i_step && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= PW'(i_a);
            r_mplier <= i_b;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides; single-cycle ops return in one
// cycle, MUL in WIDTH cycles. y/flags are registered and held under backpressure.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned RESW = WIDTH + 4;

    alu_state_t       r_state;
    alu_state_t       w_state_nx;
    logic [WIDTH-1:0] r_y;
    alu_flags_t       r_flags;

    alu_op_t          w_op;
    logic             w_accept;
    logic             w_start;
    logic             w_step;
    logic             w_load_comb;
    logic             w_load_mul;
    logic [WIDTH-1:0] w_comb_y;
    alu_flags_t       w_comb_flags;
    logic             w_mul_done_c;
    logic [PW-1:0]    w_mul_prod;
    alu_flags_t       w_mul_flags;

    assign w_op      = alu_op_t'(op);
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_RESULT) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_RESULT);
    assign busy      = (r_state != S_IDLE);
    assign y         = r_y;
    assign flags     = r_flags;

    assign {w_comb_y, w_comb_flags} =
        RESW'(alu_comb(ALU_MAXW'(a), ALU_MAXW'(b), w_op, 32'(b[SHW-1:0]), WIDTH));

    assign w_mul_flags = '{ovf:   |w_mul_prod[PW-1:WIDTH],
                           neg:   w_mul_prod[WIDTH-1],
                           carry: 1'b0,
                           zero:  (w_mul_prod[WIDTH-1:0] == '0)};

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_step   (w_step),
        .i_a      (a),
        .i_b      (b),
        .o_done_c (w_mul_done_c),
        .o_prod_c (w_mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // Next state plus load/start strobes; an accept in RESULT overlaps the drain.
    always_comb begin
        w_state_nx  = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_load_comb = 1'b0;
        w_load_mul  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_start    = 1'b1;
                        w_state_nx = S_MUL;
                    end else begin
                        w_load_comb = 1'b1;
                        w_state_nx  = S_RESULT;
                    end
                end
            end
            S_MUL: begin
                w_step = 1'b1;
                if (w_mul_done_c) begin
                    w_load_mul = 1'b1;
                    w_state_nx = S_RESULT;
                end
            end
            S_RESULT: begin
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_start    = 1'b1;
                        w_state_nx = S_MUL;
                    end else begin
                        w_load_comb = 1'b1;
                        w_state_nx  = S_RESULT;
                    end
                end else if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_flags <= '0;
        end else if (w_load_mul) begin
            r_y     <= w_mul_prod[WIDTH-1:0];
            r_flags <= w_mul_flags;
        end else if (w_load_comb) begin
            r_y     <= w_comb_y;
            r_flags <= w_comb_flags;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=8.
module tb_alu_mc;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_NOT  = 4'd5;
    localparam logic [3:0] C_SHL  = 4'd6;
    localparam logic [3:0] C_SLTU = 4'd7;
    localparam logic [3:0] C_SHR  = 4'd8;
    localparam logic [3:0] C_SRA  = 4'd9;
    localparam logic [3:0] C_SLT  = 4'd10;
    localparam logic [3:0] C_MUL  = 4'd11;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [3:0] flags;
    logic       busy;

    int total;
    int bad;

    alu_mc #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op at a falling edge; returns one falling edge later with in_valid low.
    task automatic send(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b);
        op       = t_op;
        a        = t_a;
        b        = t_b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {out_valid, busy, in_ready, flags, y}, {1'b0, 1'b0, 1'b1, 4'h0, 8'h00});
        rst_n = 1'b1;
        @(negedge clk);

        send(C_ADD, 8'hF0, 8'h20);
        check("add_y", y, 8'h10);
        check("add_flags", flags, 4'b0010);
        check("add_hs", {out_valid, in_ready, busy}, 3'b111);

        send(C_SUB, 8'h80, 8'h01);
        check("sub", {flags, y}, {4'b1000, 8'h7F});
        send(C_SLT, 8'hFF, 8'h01);
        check("slt", {flags, y}, {4'b0000, 8'h01});
        send(C_SLTU, 8'hFF, 8'h01);
        check("sltu", {flags, y}, {4'b0001, 8'h00});

        send(C_MUL, 8'h10, 8'h11);
        a  = 8'hFF;
        b  = 8'hFF;
        op = C_ADD;
        check("mul_first", {out_valid, in_ready, busy}, 3'b001);
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("mul_wait%0d", i), {out_valid, in_ready}, 2'b00);
        end
        @(negedge clk);
        check("mul_done", {out_valid, flags, y}, {1'b1, 4'b1000, 8'h10});

        send(C_ADD, 8'h01, 8'h02);
        check("b2b_add", {out_valid, flags, y}, {1'b1, 4'b0000, 8'h03});
        send(C_XOR, 8'h0F, 8'hFF);
        check("b2b_xor", {out_valid, flags, y}, {1'b1, 4'b0100, 8'hF0});
        send(C_SHL, 8'h81, 8'h01);
        check("b2b_shl", {out_valid, flags, y}, {1'b1, 4'b0010, 8'h02});
        send(C_SHL, 8'h81, 8'h08);
        check("shl_by0", {flags, y}, {4'b0100, 8'h81});
        send(C_SHR, 8'h81, 8'h09);
        check("shr_low_bits", {flags, y}, {4'b0010, 8'h40});
        send(C_SRA, 8'h81, 8'h01);
        check("sra", {flags, y}, {4'b0110, 8'hC0});
        send(C_NOT, 8'hFF, 8'h00);
        check("not", {flags, y}, {4'b0001, 8'h00});

        send(C_ADD, 8'h7F, 8'h01);
        check("bp_add", {flags, y}, {4'b1100, 8'h80});
        out_ready = 1'b0;
        op        = C_OR;
        a         = 8'h0C;
        b         = 8'h03;
        in_valid  = 1'b1;
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {out_valid, in_ready, flags, y},
                  {1'b1, 1'b0, 4'b1100, 8'h80});
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pending", {out_valid, flags, y}, {1'b1, 4'b0000, 8'h0F});

        send(C_MUL, 8'h03, 8'h05);
        repeat (3) @(negedge clk);
        check("mid_mul", {out_valid, busy}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {out_valid, busy, flags, y}, {1'b0, 1'b0, 4'h0, 8'h00});
        @(negedge clk);
        check("rst_hold", {out_valid, busy, in_ready}, 3'b001);
        rst_n = 1'b1;

        send(C_ADD, 8'h05, 8'h06);
        check("post_rst_add", {out_valid, flags, y}, {1'b1, 4'b0000, 8'h0B});
        send(4'd13, 8'h12, 8'h34);
        check("reserved", {out_valid, flags, y}, {1'b1, 4'b0001, 8'h00});
        @(negedge clk);
        check("drain_idle", {out_valid, busy, in_ready}, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the team's 8-bit combinational ALU. It accepts one operation per valid/ready handshake and returns a registered WIDTH-bit result with a four-bit flag vector through an output valid/ready handshake. It adds variable shifts, signed compare and an iterative unsigned multiply. It sits between the register-read stage and writeback, so stalls propagate through `in_ready` and `out_ready`.

## Interface
- WIDTH, 8, operand/result width; must be ≥ 4.
- SHW, $clog2(WIDTH), derived; the number of B bits used as the shift amount.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept a new operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  opcode (alu_op_t).
- out_valid  out  1  `y`/`flags` hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- y  out  WIDTH  result.
- flags  out  4  {ovf, neg, carry, zero}.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL by b[SHW-1:0]
  - 7 SLTU (y = 1 if a < b unsigned, else 0)
  - 8 SHR logical
  - 9 SRA
  - 10 SLT signed
  - 11 MUL (low WIDTH bits of a*b, unsigned)
  - 12–15 reserved: y = 0, flags = 4'b0001, no error raised
- Codes 0–7 match the legacy 3-bit ALU encoding; for shift codes, only the shift amount changes versus legacy.
- zero: y == 0, for every op.
- neg: y[WIDTH-1], for every op except reserved (0).
- carry:
  - ADD: carry-out.
  - SUB: borrow, i.e. a < b unsigned.
  - SHL: last bit shifted out.
  - SHR/SRA: last bit shifted out.
  - Shift by 0: carry = 0.
  - All other ops: carry = 0.
- ovf:
  - ADD/SUB: signed overflow.
  - MUL: upper WIDTH bits of the 2·WIDTH product ≠ 0.
  - All other ops: ovf = 0.
- FSM states IDLE, MUL, RESULT:
  - IDLE: in_ready = 1. On accept, a single-cycle op registers y/flags and goes to RESULT; MUL latches operands, clears the accumulator and counter, and goes to MUL.
  - MUL: one shift-add step per cycle; count runs 0..WIDTH-1. The step at count = WIDTH-1 writes y/flags and goes to RESULT. in_ready = 0.
  - RESULT: out_valid = 1 and y/flags are stable.
    - in_ready = out_ready.
    - If out_ready && in_valid, the new op is accepted in the same cycle: single-cycle → stay in RESULT with the new result; MUL → go to MUL.
    - If out_ready && !in_valid → IDLE.
    - If !out_ready → hold everything.
- Inputs a/b/op are sampled only on the accept edge; changes afterwards have no effect.
- Reset, including mid-MUL: state = IDLE, out_valid = 0, y = 0, flags = 0, counter and accumulator = 0, busy = 0. The in-flight op is discarded.

## Timing
- Accept = in_valid && in_ready at the rising edge.
- Single-cycle ops: out_valid is high from the edge after accept (latency 1).
- MUL: out_valid is high WIDTH edges after accept (latency WIDTH).
- Throughput: one single-cycle op per clock when out_ready stays high; MUL blocks new input for WIDTH cycles.
- in_ready is combinational from state and out_ready; there is no combinational path from in_valid to any output.
- y/flags change only when a result is registered. They remain valid, unchanged, while out_valid && !out_ready.
- Arithmetic:
  - The ADD/SUB carry is computed in WIDTH+1 bits.
  - The MUL accumulator is 2·WIDTH bits; y takes the low half.
  - Shift amounts use b[SHW-1:0] only, so amount ≥ WIDTH cannot occur when WIDTH is a power of two. For other widths, an amount ≥ WIDTH gives y = 0 (SHL/SHR) or sign fill (SRA), with carry = the last valid bit out.

## Structure
- Package alu_pkg:
  - alu_op_t: 4-bit enum, values as listed under Operation.
  - alu_flags_t: packed struct {ovf, neg, carry, zero}.
  - alu_state_t: enum IDLE/MUL/RESULT.
  - Helper function alu_comb(a, b, op) that returns the result and flags for single-cycle ops; it is parametrised via a WIDTH parameter on the package function's caller.
- Sub-module alu_mul_iter(WIDTH): start/step/done interface, 2·WIDTH accumulator, counter. alu_mc instantiates it and owns the handshake FSM.

## Test plan
- WIDTH=8, ADD a=0xF0 b=0x20, out_ready=1 → one cycle later y=0x10, flags=carry only (0b0010).
- SUB a=0x80 b=0x01 → y=0x7F, ovf=1, carry=0, neg=0. SLT a=0xFF b=0x01 → y=1. SLTU with the same operands → y=0.
- MUL a=0x10 b=0x11 → out_valid exactly 8 cycles after accept, y=0x10, ovf=1. in_ready=0 throughout MUL.
- Back-to-back: ADD, XOR, SHL(a=0x81, b=1) with out_ready=1 → three results on consecutive cycles: SHL y=0x02, carry=1.
- Backpressure: out_ready=0 for 5 cycles after an ADD result → y/flags/out_valid stable and in_ready=0. On release, the pending in_valid op is accepted in the same cycle.
- rst_n asserted mid-MUL (count=3), asynchronously between edges → outputs 0 immediately and busy=0. After release, a new ADD completes normally. Opcode 13 → y=0, flags=0b0001.
